// File: rtl/rr_decoder_arbiter_if.sv
// ============================================================================
//  Module      : rr_decoder_arbiter_if
//  Description : Request/grant bundle between four requesters and the
//                round-robin decoder arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_decoder_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_en;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_en,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_en,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/rr_decoder_arbiter.sv
// ============================================================================
//  Module      : rr_decoder_arbiter
//  Description : Four-way round-robin arbiter driving a shared 2-to-4 decoder,
//                with registered one-hot grant and bounded hold time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_decoder_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_max_hold   = CNT_W'(MAX_HOLD);
    localparam logic             c_timeout_en = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] c_cnt_start  = c_timeout_en ? CNT_W'(1) : '0;
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_idx;
    logic             r_gnt_en;
    logic             r_timeout;

    logic [7:0]       w_req_dbl;
    logic [3:0]       w_req_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_pick;
    logic [3:0]       w_pick_dec;
    logic             w_any;
    logic             w_owner_req;
    logic             w_hold_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    assign w_req_dbl = {bus.req, bus.req};
    assign w_req_rot = w_req_dbl[r_ptr +: 4];
    assign w_any     = |bus.req;

    always_comb begin
        w_off = '0;
        for (int i = 3; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = 2'(i);
            end
        end
    end

    assign w_pick = r_ptr + w_off;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            assign w_pick_dec[gi] = (w_pick == 2'(gi));
        end
    endgenerate

    // gnt_idx doubles as the current owner; it is frozen for the whole BUSY state.
    assign w_owner_req = bus.req[r_gnt_idx];
    assign w_hold_hit  = c_timeout_en && (r_hold_cnt == c_max_hold);
    assign w_cnt_inc   = (r_hold_cnt == c_max_hold) ? r_hold_cnt : r_hold_cnt + c_cnt_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_gnt_en   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state    <= S_BUSY;
                        r_gnt_idx  <= w_pick;
                        r_gnt      <= w_pick_dec;
                        r_gnt_en   <= 1'b1;
                        r_hold_cnt <= c_cnt_start;
                    end
                end
                S_BUSY: begin
                    // A release on the limit cycle wins over the timeout.
                    if (!w_owner_req || w_hold_hit) begin
                        r_state    <= S_GAP;
                        r_ptr      <= r_gnt_idx + 2'd1;
                        r_gnt      <= '0;
                        r_gnt_en   <= 1'b0;
                        r_hold_cnt <= '0;
                        r_timeout  <= w_owner_req;
                    end else begin
                        r_hold_cnt <= w_cnt_inc;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.gnt_en  = r_gnt_en;
    assign bus.timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_decoder_arbiter.sv
// ============================================================================
//  Module      : tb_rr_decoder_arbiter
//  Description : Directed bench for rr_decoder_arbiter (MAX_HOLD=8 and 0).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_decoder_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_decoder_arbiter_if bus8 ();
    rr_decoder_arbiter_if bus0 ();

    rr_decoder_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    rr_decoder_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Structural grant rules on both instances, every cycle.
    always @(negedge clk) begin
        chk("onehot8", 8'($onehot0(bus8.gnt)), 8'd1);
        chk("dec8", 8'(bus8.gnt), 8'(bus8.gnt_en ? (4'b0001 << bus8.gnt_idx) : 4'b0000));
        chk("onehot0", 8'($onehot0(bus0.gnt)), 8'd1);
        chk("dec0", 8'(bus0.gnt), 8'(bus0.gnt_en ? (4'b0001 << bus0.gnt_idx) : 4'b0000));
        chk("nto0", 8'(bus0.timeout), 8'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_gnt;
        int cur;
        int nxt;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus8.req  = 4'b0000;
        bus0.req  = 4'b0000;
        tick();
        tick();
        chk("rst_gnt", 8'(bus8.gnt), 8'h0);
        chk("rst_idx", 8'(bus8.gnt_idx), 8'h0);
        chk("rst_en", 8'(bus8.gnt_en), 8'h0);
        chk("rst_to", 8'(bus8.timeout), 8'h0);

        // First grant, then asynchronous reset in the middle of BUSY.
        rst_n    = 1'b1;
        bus8.req = 4'b0100;
        tick();
        chk("g2_gnt", 8'(bus8.gnt), 8'h4);
        chk("g2_idx", 8'(bus8.gnt_idx), 8'h2);
        chk("g2_en", 8'(bus8.gnt_en), 8'h1);
        tick();
        tick();
        chk("g2_hold", 8'(bus8.gnt), 8'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 8'(bus8.gnt), 8'h0);
        chk("arst_en", 8'(bus8.gnt_en), 8'h0);
        chk("arst_idx", 8'(bus8.gnt_idx), 8'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst", 8'(bus8.gnt), 8'h4);

        // Release owner 2: GAP keeps gnt_idx, pointer moves to 3.
        bus8.req = 4'b0000;
        tick();
        chk("gap_gnt", 8'(bus8.gnt), 8'h0);
        chk("gap_idx", 8'(bus8.gnt_idx), 8'h2);
        chk("gap_en", 8'(bus8.gnt_en), 8'h0);
        tick();
        chk("idle_gnt", 8'(bus8.gnt), 8'h0);

        // ptr=3 with req=0101 wraps to requester 0 before 2.
        bus8.req = 4'b0101;
        tick();
        chk("wrap_gnt", 8'(bus8.gnt), 8'h1);
        chk("wrap_idx", 8'(bus8.gnt_idx), 8'h0);

        // Fairness: owner drops for the gap, everyone else stays requesting.
        cur = 0;
        for (int k = 0; k < 4; k++) begin
            nxt      = (cur + 1) % 4;
            bus8.req = 4'b1111 & ~(4'b0001 << cur);
            tick();
            chk("fair_gap", 8'(bus8.gnt), 8'h0);
            chk("fair_to", 8'(bus8.timeout), 8'h0);
            tick();
            chk("fair_idle", 8'(bus8.gnt), 8'h0);
            bus8.req = 4'b1111;
            tick();
            exp_gnt = 4'b0001 << nxt;
            chk("fair_gnt", 8'(bus8.gnt), 8'(exp_gnt));
            cur = nxt;
        end

        // Timeout: owner 0 (hold_cnt=1 now) with req=0011 held.
        bus8.req = 4'b0011;
        repeat (7) tick();
        chk("to0_hold", 8'(bus8.gnt), 8'h1);
        chk("to0_pre", 8'(bus8.timeout), 8'h0);
        tick();
        chk("to0_gap", 8'(bus8.gnt), 8'h0);
        chk("to0_pulse", 8'(bus8.timeout), 8'h1);
        tick();
        chk("to0_end", 8'(bus8.timeout), 8'h0);
        tick();
        chk("to1_gnt", 8'(bus8.gnt), 8'h2);
        repeat (7) tick();
        chk("to1_hold", 8'(bus8.gnt), 8'h2);
        tick();
        chk("to1_pulse", 8'(bus8.timeout), 8'h1);
        tick();
        tick();
        chk("to_back0", 8'(bus8.gnt), 8'h1);

        // Owner 0 drops on the very edge its hold count reaches 8.
        repeat (7) tick();
        chk("co_hold", 8'(bus8.gnt), 8'h1);
        bus8.req = 4'b0010;
        tick();
        chk("co_gap", 8'(bus8.gnt), 8'h0);
        chk("co_to", 8'(bus8.timeout), 8'h0);
        tick();
        tick();
        chk("co_next", 8'(bus8.gnt), 8'h2);

        // MAX_HOLD=0: a single requester is never revoked.
        bus0.req = 4'b1000;
        tick();
        chk("nh_gnt", 8'(bus0.gnt), 8'h8);
        chk("nh_idx", 8'(bus0.gnt_idx), 8'h3);
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("nh_keep", 8'(bus0.gnt), 8'h8);
        end
        bus0.req = 4'b0000;
        tick();
        chk("nh_gap", 8'(bus0.gnt), 8'h0);
        chk("nh_gap_to", 8'(bus0.timeout), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
